// File: rtl/wishbone_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wishbone_rr_arbiter_pkg
//   Shared definitions for the round-robin Wishbone arbiter: bus widths,
//   round-robin pointer width and the arbiter state encoding.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package wishbone_rr_arbiter_pkg;

    // Slave bus geometry: 16-bit address, 8-bit data
    localparam int WB_ADR_W = 16;
    localparam int WB_DAT_W = 8;

    // Round-robin pointer is wide enough for up to 8 masters
    localparam int PTR_W = 3;

    // Arbiter states: IDLE waits for a requester, OWN holds the bus for one tenure
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wishbone_rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// wb_rr_pick
//   Combinational round-robin selector. Picks the first asserted request at
//   or after ptr_i, wrapping modulo NUM_MASTERS.
//   Ports:
//     req_i   [NUM_MASTERS]  request vector
//     ptr_i   [3]            round-robin start position (< NUM_MASTERS)
//     gnt_o   [NUM_MASTERS]  one-hot pick, zero when no request
//     valid_o                at least one request present
// ---------------------------------------------------------------------------
module wb_rr_pick
    import wishbone_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [PTR_W-1:0]       ptr_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   valid_o
);

    logic [2*NUM_MASTERS-1:0] reqDouble;
    logic [2*NUM_MASTERS-1:0] keepMask;
    logic [2*NUM_MASTERS-1:0] maskedReq;
    logic [2*NUM_MASTERS-1:0] lowestReq;

    // The request vector is doubled so that a search starting at ptr_i can
    // run off the top of the first copy into the second, which is the wrap.
    // Bits below ptr_i in the lower copy are masked; the upper copy is always
    // intact, so any request guarantees a hit. Isolating the lowest set bit
    // (x & -x) is the priority encoder, and folding both halves together
    // turns the doubled index back into a master number.
    always_comb begin
        reqDouble = {req_i, req_i};
        keepMask  = {(2*NUM_MASTERS){1'b1}} << ptr_i;
        maskedReq = reqDouble & keepMask;
        lowestReq = maskedReq & (~maskedReq + (2*NUM_MASTERS)'(1));
        gnt_o     = lowestReq[NUM_MASTERS-1:0] | lowestReq[2*NUM_MASTERS-1:NUM_MASTERS];
        valid_o   = |req_i;
    end

endmodule

// File: rtl/wishbone_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wishbone_rr_arbiter
//   Round-robin arbiter sharing one Wishbone slave (16-bit address, 8-bit
//   data) among NUM_MASTERS masters. A grant is held for the whole CYC
//   tenure; terminations are routed to the owner only.
//   Optional feature macro: WB_ARB_TIMEOUT_EN -- adds a watchdog that turns
//   a slave stalled for TIMEOUT_CYCLES strobed cycles into a one-cycle ERR.
//   Ports:
//     clk_i, rst_n_i                     clock, async active-low reset
//     m_cyc_i/m_stb_i/m_wr_i [NM]        per-master strobes
//     m_adr_i [NM*16], m_dat_i [NM*8]    per-master address / write data
//     m_ack_o/m_err_o/m_rty_o [NM]       terminations to the owner only
//     m_dat_o [8]                        read data, broadcast
//     s_cyc_o/s_stb_o/s_wr_o, s_adr_o, s_dat_o   slave-side request
//     s_ack_i/s_err_i/s_rty_i, s_dat_i   slave-side response
//     gnt_o [NM]                         one-hot owner, zero when idle
//     busy_o                             high while a master owns the bus
// ---------------------------------------------------------------------------
module wishbone_rr_arbiter
    import wishbone_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_MASTERS-1:0]          m_cyc_i,
    input  logic [NUM_MASTERS-1:0]          m_stb_i,
    input  logic [NUM_MASTERS-1:0]          m_wr_i,
    input  logic [NUM_MASTERS*WB_ADR_W-1:0] m_adr_i,
    input  logic [NUM_MASTERS*WB_DAT_W-1:0] m_dat_i,
    output logic [NUM_MASTERS-1:0]          m_ack_o,
    output logic [NUM_MASTERS-1:0]          m_err_o,
    output logic [NUM_MASTERS-1:0]          m_rty_o,
    output logic [WB_DAT_W-1:0]             m_dat_o,
    output logic                            s_cyc_o,
    output logic                            s_stb_o,
    output logic                            s_wr_o,
    output logic [WB_ADR_W-1:0]             s_adr_o,
    output logic [WB_DAT_W-1:0]             s_dat_o,
    input  logic                            s_ack_i,
    input  logic                            s_err_i,
    input  logic                            s_rty_i,
    input  logic [WB_DAT_W-1:0]             s_dat_i,
    output logic [NUM_MASTERS-1:0]          gnt_o,
    output logic                            busy_o
);

    // Reject out-of-range configurations at elaboration
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_paramCheck
        $error("wishbone_rr_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES 1..255");
    end

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0]       rrPtr_q, rrPtr_d;
    logic [NUM_MASTERS-1:0] pickGnt;
    logic                   pickValid;
    logic [PTR_W-1:0]       ownerIdx;
    logic [PTR_W-1:0]       nextPtr;
    logic                   wdFire;

    wb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .req_i   (m_cyc_i),
        .ptr_i   (rrPtr_q),
        .gnt_o   (pickGnt),
        .valid_o (pickValid)
    );

    // Binary index of the current owner, and the pointer that follows it
    always_comb begin
        ownerIdx = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (gnt_q[k]) begin
                ownerIdx = PTR_W'(k);
            end
        end
        nextPtr = (ownerIdx == PTR_W'(NUM_MASTERS - 1)) ? '0 : ownerIdx + PTR_W'(1);
    end

    // AND-OR mux of the owner's request onto the slave. Because gnt_q is
    // zero in IDLE and cleared asynchronously by reset, s_cyc_o drops the
    // instant reset asserts.
    always_comb begin
        s_cyc_o = |(m_cyc_i & gnt_q);
        s_stb_o = |(m_stb_i & gnt_q);
        s_wr_o  = |(m_wr_i  & gnt_q);
        s_adr_o = '0;
        s_dat_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (gnt_q[k]) begin
                s_adr_o = m_adr_i[k*WB_ADR_W +: WB_ADR_W];
                s_dat_o = m_dat_i[k*WB_DAT_W +: WB_DAT_W];
            end
        end
    end

    // Next-state logic: grant from IDLE, release when the owner drops CYC.
    // The pointer only advances on release, so a CYC-holding owner is never
    // preempted.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rrPtr_d = rrPtr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pickValid) begin
                    gnt_d   = pickGnt;
                    state_d = ARB_OWN;
                end
            end
            ARB_OWN: begin
                if (!s_cyc_o) begin
                    gnt_d   = '0;
                    rrPtr_d = nextPtr;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State, grant and pointer registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            rrPtr_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rrPtr_q <= rrPtr_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] wdCnt_q, wdCnt_d;
    logic       wdStalled;

    // Count strobed OWN cycles without a termination. The ERR fires in the
    // cycle the count would reach TIMEOUT_CYCLES, then the count restarts
    // while the grant stays with the owner.
    always_comb begin
        wdStalled = (state_q == ARB_OWN) && s_stb_o && !(s_ack_i || s_err_i || s_rty_i);
        wdFire    = wdStalled && (wdCnt_q == 8'(TIMEOUT_CYCLES - 1));
        wdCnt_d   = '0;
        if (wdStalled && !wdFire && (state_d == ARB_OWN)) begin
            wdCnt_d = wdCnt_q + 8'd1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wdCnt_q <= '0;
        end else begin
            wdCnt_q <= wdCnt_d;
        end
    end
`else
    assign wdFire = 1'b0;
`endif

    // Terminations reach the owner only; nothing passes outside OWN
    assign m_ack_o = gnt_q & {NUM_MASTERS{s_ack_i}};
    assign m_rty_o = gnt_q & {NUM_MASTERS{s_rty_i}};
    assign m_err_o = gnt_q & {NUM_MASTERS{s_err_i | wdFire}};
    assign m_dat_o = s_dat_i;
    assign gnt_o   = gnt_q;
    assign busy_o  = (state_q == ARB_OWN);

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wishbone_rr_arbiter
//   Directed bench for the 4-master round-robin Wishbone arbiter. Each task
//   drives one scenario and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_wishbone_rr_arbiter;

    localparam int NM = 4;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic [NM-1:0]    m_cyc_i, m_stb_i, m_wr_i;
    logic [NM*16-1:0] m_adr_i;
    logic [NM*8-1:0]  m_dat_i;
    logic [NM-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic [7:0]       m_dat_o;
    logic             s_cyc_o, s_stb_o, s_wr_o;
    logic [15:0]      s_adr_o;
    logic [7:0]       s_dat_o;
    logic             s_ack_i, s_err_i, s_rty_i;
    logic [7:0]       s_dat_i;
    logic [NM-1:0]    gnt_o;
    logic             busy_o;

    int errCount   = 0;
    int checkCount = 0;

    wishbone_rr_arbiter #(
        .NUM_MASTERS    (NM),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_wr_i  (m_wr_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_rty_o (m_rty_o),
        .m_dat_o (m_dat_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_wr_o  (s_wr_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .s_rty_i (s_rty_i),
        .s_dat_i (s_dat_i),
        .gnt_o   (gnt_o),
        .busy_o  (busy_o)
    );

    // 100 MHz clock
    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drive every master and slave input to its quiet value
    task automatic applyStimulus();
        m_cyc_i = '0;
        m_stb_i = '0;
        m_wr_i  = '0;
        m_adr_i = '0;
        m_dat_i = '0;
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        s_rty_i = 1'b0;
        s_dat_i = '0;
    endtask

    // Quiet inputs, pulse reset for two edges, release just after an edge
    task automatic applyReset();
        applyStimulus();
        rst_n_i = 1'b0;
        step();
        step();
        rst_n_i = 1'b1;
    endtask

    // Reset holds everything off despite requests; first grant one cycle after release
    task automatic test_reset();
        applyStimulus();
        rst_n_i = 1'b0;
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        step();
        step();
        s_ack_i = 1'b1;
        s_err_i = 1'b1;
        #1;
        checkCount++;
        if (gnt_o !== 4'b0000) begin
            errCount++;
            $display("[TB] FAIL reset_gnt: got %b expected %b", gnt_o, 4'b0000);
        end
        checkCount++;
        if (s_cyc_o !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL reset_s_cyc: got %b expected %b", s_cyc_o, 1'b0);
        end
        checkCount++;
        if (busy_o !== 1'b0) begin
            errCount++;
            $display("[TB] FAIL reset_busy: got %b expected %b", busy_o, 1'b0);
        end
        checkCount++;
        if ((m_ack_o | m_err_o | m_rty_o) !== 4'b0000) begin
            errCount++;
            $display("[TB] FAIL reset_terms: got ack=%b err=%b expected 0000", m_ack_o, m_err_o);
        end
        s_ack_i = 1'b0;
        s_err_i = 1'b0;
        rst_n_i = 1'b1;
        step();
        checkCount++;
        if (gnt_o !== 4'b0001) begin
            errCount++;
            $display("[TB] FAIL reset_release_gnt: got %b expected %b", gnt_o, 4'b0001);
        end
        checkCount++;
        if (s_cyc_o !== 1'b1 || busy_o !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL reset_release_busy: got cyc=%b busy=%b expected 1 1", s_cyc_o, busy_o);
        end
        m_cyc_i = '0;
        m_stb_i = '0;
        step();
    endtask

    // All four request continuously; each owner takes one ACK then releases
    task automatic test_fairness();
        logic [NM-1:0] expGnt [5];
        expGnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        applyReset();
        m_cyc_i = 4'b1111;
        m_stb_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            checkCount++;
            if (gnt_o !== expGnt[i]) begin
                errCount++;
                $display("[TB] FAIL fair_gnt_%0d: got %b expected %b", i, gnt_o, expGnt[i]);
            end
            s_ack_i = 1'b1;
            m_cyc_i = m_cyc_i & ~expGnt[i];
            m_stb_i = m_stb_i & ~expGnt[i];
            #1;
            checkCount++;
            if (m_ack_o !== expGnt[i]) begin
                errCount++;
                $display("[TB] FAIL fair_ack_%0d: got %b expected %b", i, m_ack_o, expGnt[i]);
            end
            step();
            checkCount++;
            if (gnt_o !== 4'b0000 || m_ack_o !== 4'b0000) begin
                errCount++;
                $display("[TB] FAIL fair_idle_%0d: got gnt=%b ack=%b expected 0000 0000", i, gnt_o, m_ack_o);
            end
            s_ack_i = 1'b0;
            m_cyc_i = m_cyc_i | expGnt[i];
            m_stb_i = m_stb_i | expGnt[i];
        end
        applyStimulus();
        step();
        step();
    endtask

    // Master 1 reads 0x1234 while master 2 waits; data and ACK reach m1 only
    task automatic test_routing();
        applyReset();
        m_adr_i[31:16] = 16'h1234;
        m_adr_i[47:32] = 16'hBEEF;
        m_cyc_i = 4'b0110;
        m_stb_i = 4'b0110;
        m_wr_i  = 4'b0100;
        step();
        checkCount++;
        if (gnt_o !== 4'b0010) begin
            errCount++;
            $display("[TB] FAIL route_gnt: got %b expected %b", gnt_o, 4'b0010);
        end
        checkCount++;
        if (s_adr_o !== 16'h1234 || s_wr_o !== 1'b0 || s_stb_o !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL route_req: got adr=%h wr=%b stb=%b expected 1234 0 1", s_adr_o, s_wr_o, s_stb_o);
        end
        s_ack_i = 1'b1;
        s_dat_i = 8'hA5;
        #1;
        checkCount++;
        if (m_ack_o !== 4'b0010) begin
            errCount++;
            $display("[TB] FAIL route_ack: got %b expected %b", m_ack_o, 4'b0010);
        end
        checkCount++;
        if (m_dat_o !== 8'hA5) begin
            errCount++;
            $display("[TB] FAIL route_dat: got %h expected %h", m_dat_o, 8'hA5);
        end
        s_ack_i    = 1'b0;
        m_cyc_i[1] = 1'b0;
        m_stb_i[1] = 1'b0;
        step();
        step();
        checkCount++;
        if (gnt_o !== 4'b0100 || s_adr_o !== 16'hBEEF || s_wr_o !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL route_next: got gnt=%b adr=%h wr=%b expected 0100 beef 1", gnt_o, s_adr_o, s_wr_o);
        end
        applyStimulus();
        step();
        step();
    endtask

    // Reset during m3's write tenure kills the cycle at once and clears the pointer
    task automatic test_midreset();
        applyReset();
        m_cyc_i = 4'b0010;
        m_stb_i = 4'b0010;
        step();
        m_cyc_i = '0;
        m_stb_i = '0;
        step();
        m_cyc_i        = 4'b1000;
        m_stb_i        = 4'b1000;
        m_wr_i         = 4'b1000;
        m_adr_i[63:48] = 16'h00F0;
        m_dat_i[31:24] = 8'h55;
        step();
        checkCount++;
        if (gnt_o !== 4'b1000 || s_dat_o !== 8'h55 || s_wr_o !== 1'b1) begin
            errCount++;
            $display("[TB] FAIL midrst_own: got gnt=%b dat=%h wr=%b expected 1000 55 1", gnt_o, s_dat_o, s_wr_o);
        end
        #2;
        rst_n_i = 1'b0;
        #1;
        checkCount++;
        if (s_cyc_o !== 1'b0 || gnt_o !== 4'b0000) begin
            errCount++;
            $display("[TB] FAIL midrst_drop: got cyc=%b gnt=%b expected 0 0000", s_cyc_o, gnt_o);
        end
        step();
        rst_n_i = 1'b1;
        m_cyc_i = 4'b1001;
        m_stb_i = 4'b1001;
        step();
        checkCount++;
        if (gnt_o !== 4'b0001) begin
            errCount++;
            $display("[TB] FAIL midrst_ptr: got %b expected %b", gnt_o, 4'b0001);
        end
        applyStimulus();
        step();
        step();
    endtask

    // Slave never answers m0's strobe
    task automatic test_watchdog();
        applyReset();
        m_cyc_i = 4'b0001;
        m_stb_i = 4'b0001;
        step();
`ifdef WB_ARB_TIMEOUT_EN
        for (int c = 1; c <= 20; c++) begin
            logic [NM-1:0] expErr;
            if (c > 1) step();
            expErr = (c == 16) ? 4'b0001 : 4'b0000;
            checkCount++;
            if (m_err_o !== expErr) begin
                errCount++;
                $display("[TB] FAIL wd_err_c%0d: got %b expected %b", c, m_err_o, expErr);
            end
        end
`else
        begin
            logic errSeen;
            errSeen = 1'b0;
            for (int c = 1; c <= 1000; c++) begin
                if (m_err_o !== 4'b0000) errSeen = 1'b1;
                step();
            end
            checkCount++;
            if (errSeen !== 1'b0) begin
                errCount++;
                $display("[TB] FAIL wd_no_err: got %b expected %b", errSeen, 1'b0);
            end
        end
`endif
        checkCount++;
        if (gnt_o !== 4'b0001) begin
            errCount++;
            $display("[TB] FAIL wd_gnt_kept: got %b expected %b", gnt_o, 4'b0001);
        end
        applyStimulus();
        step();
        step();
    endtask

    // m2 drops CYC in its ACK cycle while m0 waits
    task automatic test_release_ack();
        applyReset();
        m_cyc_i = 4'b0100;
        m_stb_i = 4'b0100;
        step();
        checkCount++;
        if (gnt_o !== 4'b0100) begin
            errCount++;
            $display("[TB] FAIL relack_gnt: got %b expected %b", gnt_o, 4'b0100);
        end
        m_cyc_i = 4'b0001;
        m_stb_i = 4'b0001;
        s_ack_i = 1'b1;
        #1;
        checkCount++;
        if (m_ack_o !== 4'b0100) begin
            errCount++;
            $display("[TB] FAIL relack_ack: got %b expected %b", m_ack_o, 4'b0100);
        end
        step();
        s_ack_i = 1'b0;
        checkCount++;
        if (gnt_o !== 4'b0000) begin
            errCount++;
            $display("[TB] FAIL relack_idle: got %b expected %b", gnt_o, 4'b0000);
        end
        step();
        checkCount++;
        if (gnt_o !== 4'b0001) begin
            errCount++;
            $display("[TB] FAIL relack_next: got %b expected %b", gnt_o, 4'b0001);
        end
        applyStimulus();
        step();
    endtask

    // Run every scenario in order, then report
    initial begin
        rst_n_i = 1'b0;
        applyStimulus();
        test_reset();
        test_fairness();
        test_routing();
        test_midreset();
        test_watchdog();
        test_release_ack();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
